// File: rtl/pixel_feeder.sv
// ============================================================================
// Module   : pixel_feeder
// Function : Streams a W x H 8-bit frame from a 1-cycle-latency memory to the
//            2D filter as GAP-spaced strobes; optional zero-pixel flush tail
//            enabled by defining PIXEL_FEEDER_FLUSH_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pixel_feeder #(
  parameter int W   = 256,
  parameter int H   = 256,
  parameter int GAP = 8,
  parameter int AW  = 16
) (
  input  logic          clk,
  input  logic          n_reset,
  input  logic          start,
  input  logic          stall,
  output logic          busy,
  output logic          done,
  output logic          m_cs,
  output logic [AW-1:0] m_addr,
  input  logic [7:0]    m_din,
  output logic          o_strb,
  output logic [7:0]    o_data
);

  localparam logic [1:0]    c_IDLE     = 2'd0;
  localparam logic [1:0]    c_READ     = 2'd1;
  localparam logic [1:0]    c_FIN      = 2'd3;
  localparam logic [7:0]    c_GAP_MAX  = 8'(GAP - 1);
  localparam logic [AW-1:0] c_LAST_PIX = AW'(W * H - 1);
`ifdef PIXEL_FEEDER_FLUSH_EN
  localparam logic [1:0]    c_FLUSH    = 2'd2;
  localparam int            c_FL_W     = $clog2(W + 2);
  localparam logic [c_FL_W-1:0] c_FL_LAST = c_FL_W'(W);
  logic [c_FL_W-1:0] r_fl_cnt;
`endif

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic [7:0]    r_gap_cnt;
  logic [AW-1:0] r_pix_cnt;
  logic [AW-1:0] r_addr_hold;
  logic          r_iss_d1;
  logic          r_mem_d1;
  logic          r_strb;
  logic [7:0]    r_data;
  logic          r_done;
  logic          w_active;
  logic          w_issue;
  logic          w_mem_issue;
  logic          w_accept;

  // State register
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) r_state <= c_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE: if (w_accept) w_state_nxt = c_READ;
      c_READ: if (w_mem_issue && r_pix_cnt == c_LAST_PIX) begin
`ifdef PIXEL_FEEDER_FLUSH_EN
        w_state_nxt = c_FLUSH;
`else
        w_state_nxt = c_FIN;
`endif
      end
`ifdef PIXEL_FEEDER_FLUSH_EN
      c_FLUSH: if (w_issue && r_fl_cnt == c_FL_LAST) w_state_nxt = c_FIN;
`endif
      // Only the final strobe can appear once FIN is entered.
      c_FIN:  if (r_strb) w_state_nxt = c_IDLE;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    w_active = (r_state == c_READ);
`ifdef PIXEL_FEEDER_FLUSH_EN
    w_active = w_active || (r_state == c_FLUSH);
`endif
    w_issue     = w_active && (r_gap_cnt == c_GAP_MAX) && !stall;
    w_mem_issue = w_issue && (r_state == c_READ);
    // A start landing on the done pulse is dropped.
    w_accept    = (r_state == c_IDLE) && start && !r_done;
    busy        = (r_state != c_IDLE) || r_done;
    m_cs        = w_mem_issue;
    m_addr      = w_mem_issue ? r_pix_cnt : r_addr_hold;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_gap_cnt   <= '0;
      r_pix_cnt   <= '0;
      r_addr_hold <= '0;
      r_iss_d1    <= 1'b0;
      r_mem_d1    <= 1'b0;
      r_strb      <= 1'b0;
      r_data      <= '0;
      r_done      <= 1'b0;
    end else begin
      if (w_accept)                    r_gap_cnt <= c_GAP_MAX;
      else if (w_issue)                r_gap_cnt <= '0;
      else if (r_gap_cnt != c_GAP_MAX) r_gap_cnt <= r_gap_cnt + 8'd1;

      if (w_accept)         r_pix_cnt <= '0;
      else if (w_mem_issue) r_pix_cnt <= r_pix_cnt + 1'b1;

      if (w_mem_issue) r_addr_hold <= r_pix_cnt;

      r_iss_d1 <= w_issue;
      r_mem_d1 <= w_mem_issue;
      if (r_iss_d1) r_data <= r_mem_d1 ? m_din : 8'd0;
      r_strb   <= r_iss_d1;
      r_done   <= (r_state == c_FIN) && r_strb;
    end
  end

`ifdef PIXEL_FEEDER_FLUSH_EN
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset)                              r_fl_cnt <= '0;
    else if (w_state_nxt == c_FLUSH && r_state == c_READ) r_fl_cnt <= '0;
    else if (w_issue && r_state == c_FLUSH)    r_fl_cnt <= r_fl_cnt + 1'b1;
  end
`endif

  assign done   = r_done;
  assign o_strb = r_strb;
  assign o_data = r_data;

endmodule

`default_nettype wire

// File: tb/tb_pixel_feeder.sv
// ============================================================================
// Module   : tb_pixel_feeder
// Function : Directed checks for pixel_feeder (W=H=4); GAP=8 and GAP=6 units.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pixel_feeder;
  localparam int W = 4, H = 4, GAP = 8, AW = 16, NPIX = W * H;
`ifdef PIXEL_FEEDER_FLUSH_EN
  localparam int NFL = W + 1;
`else
  localparam int NFL = 0;
`endif
  localparam int NSTRB = NPIX + NFL;

  logic clk = 1'b0, n_reset = 1'b0, start = 1'b0, stall = 1'b0;
  logic busy, done, m_cs, o_strb;
  logic [AW-1:0] m_addr;
  logic [7:0] m_din = 8'd0, o_data;

  logic start2 = 1'b0, stall2 = 1'b0;
  logic busy2, done2, m_cs2, o_strb2;
  logic [AW-1:0] m_addr2;
  logic [7:0] m_din2 = 8'd0, o_data2;

  int checks = 0, errors = 0, cyc = 0;

  pixel_feeder #(.W(W), .H(H), .GAP(GAP), .AW(AW)) dut (
    .clk(clk), .n_reset(n_reset), .start(start), .stall(stall),
    .busy(busy), .done(done), .m_cs(m_cs), .m_addr(m_addr), .m_din(m_din),
    .o_strb(o_strb), .o_data(o_data));

  pixel_feeder #(.W(W), .H(H), .GAP(6), .AW(AW)) dut6 (
    .clk(clk), .n_reset(n_reset), .start(start2), .stall(stall2),
    .busy(busy2), .done(done2), .m_cs(m_cs2), .m_addr(m_addr2), .m_din(m_din2),
    .o_strb(o_strb2), .o_data(o_data2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Frame memory model: mem[i] = i + 1, one-cycle read latency
  always @(posedge clk) begin
    if (m_cs)  m_din  <= 8'(m_addr + 1);
    if (m_cs2) m_din2 <= 8'(m_addr2 + 1);
  end

  typedef struct {
    logic       start;
    logic       e_busy;
    logic       e_cs;
    logic [15:0] e_addr;
    logic       e_strb;
    logic [7:0] e_data;
    logic       e_done;
  } vec_t;
  vec_t tbl [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic stream_frame(input int stall_after, input int stall_len,
                              input int reset_at, input int start_again_at);
    int s, nstrb, ncs, last_strb, last_cs, stall_left, budget;
    bit fin;
    nstrb = 0; ncs = 0; last_strb = 0; last_cs = -100; stall_left = 0; fin = 0;
    budget = NSTRB * GAP + stall_len + 40;
    @(negedge clk); start = 1'b1; s = cyc;
    for (int k = 1; k <= budget && !fin; k++) begin
      @(negedge clk);
      start = (k == start_again_at);
      stall = (stall_left > 0);
      if (stall_left > 0) stall_left--;
      #1;
      if (k == 1) begin
        chk("busy_after_start", busy, 1);
        chk("first_issue", m_cs, 1);
      end
      if (stall) chk("no_issue_in_stall", m_cs, 0);
      if (m_cs) begin
        chk("m_addr", m_addr, ncs);
        ncs++; last_cs = cyc;
      end
      if (o_strb) begin
        if (nstrb == 0)          chk("first_strb_latency", cyc - s, 3);
        else if (stall_len == 0) chk("strb_spacing", cyc - last_strb, GAP);
        else                     chk("strb_spacing_min", 32'(cyc - last_strb >= GAP), 1);
        if (nstrb < NPIX) begin
          chk("o_data", o_data, nstrb + 1);
          chk("read_to_strb", cyc - last_cs, 2);
        end else begin
          chk("flush_data", o_data, 0);
        end
        nstrb++; last_strb = cyc;
        if (nstrb == stall_after) stall_left = stall_len;
        if (nstrb == reset_at) begin
          n_reset = 1'b0; #1;
          chk("rst_o_strb", o_strb, 0);
          chk("rst_m_cs", m_cs, 0);
          chk("rst_busy", busy, 0);
          chk("rst_o_data", o_data, 0);
          @(negedge clk); n_reset = 1'b1; start = 1'b0; stall = 1'b0;
          return;
        end
      end
      if (done) begin
        fin = 1;
        chk("done_strb_count", nstrb, NSTRB);
        chk("done_after_last_strb", cyc - last_strb, 1);
        chk("mem_reads", ncs, NPIX);
        chk("busy_at_done", busy, 1);
        if (stall_len == 0) chk("done_latency", cyc - s, 3 + GAP * (NSTRB - 1) + 1);
        start = 1'b1;
        @(negedge clk); start = 1'b0; #1;
        chk("busy_after_done", busy, 0);
        chk("start_at_done_ignored", m_cs, 0);
      end
    end
    stall = 1'b0; start = 1'b0;
    chk("frame_completed", 32'(fin), 1);
  endtask

  task automatic gap6_frame();
    int n, last;
    bit fin;
    n = 0; last = 0; fin = 0;
    @(negedge clk); start2 = 1'b1;
    for (int k = 1; k <= NSTRB * 6 + 40 && !fin; k++) begin
      @(negedge clk); start2 = 1'b0; #1;
      if (o_strb2) begin
        if (n > 0)    chk("gap6_spacing", cyc - last, 6);
        if (n < NPIX) chk("gap6_data", o_data2, n + 1);
        n++; last = cyc;
      end
      if (done2) fin = 1;
    end
    chk("gap6_completed", 32'(fin), 1);
    chk("gap6_strb_count", n, NSTRB);
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 8'd0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 16'd0, 1'b0, 8'd0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 8'd0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 16'd0, 1'b1, 8'd1, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 8'd1, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 8'd1, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 8'd1, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 8'd1, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 8'd1, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 16'd1, 1'b0, 8'd1, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 16'd1, 1'b0, 8'd1, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 16'd1, 1'b1, 8'd2, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 16'd1, 1'b0, 8'd2, 1'b0};

    repeat (3) @(negedge clk);
    n_reset = 1'b1;

    // Reset values and first cycles of a frame, one row per cycle
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      start = tbl[i].start;
      #1;
      chk($sformatf("vec%0d_busy", i),   busy,   tbl[i].e_busy);
      chk($sformatf("vec%0d_m_cs", i),   m_cs,   tbl[i].e_cs);
      chk($sformatf("vec%0d_m_addr", i), m_addr, tbl[i].e_addr);
      chk($sformatf("vec%0d_o_strb", i), o_strb, tbl[i].e_strb);
      chk($sformatf("vec%0d_o_data", i), o_data, tbl[i].e_data);
      chk($sformatf("vec%0d_done", i),   done,   tbl[i].e_done);
    end

    // Asynchronous reset mid-frame
    @(negedge clk); n_reset = 1'b0; #1;
    chk("midrst_o_strb", o_strb, 0);
    chk("midrst_m_cs", m_cs, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_o_data", o_data, 0);
    chk("midrst_m_addr", m_addr, 0);
    @(negedge clk); n_reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      chk("idle_m_cs", m_cs, 0);
      chk("idle_o_strb", o_strb, 0);
      chk("idle_busy", busy, 0);
    end

    stream_frame(0, 0, 0, 40);   // clean frame with a start pulse while busy
    stream_frame(5, 30, 0, 0);   // stall after the 5th strobe
    stream_frame(0, 0, 7, 0);    // reset at the 7th strobe
    stream_frame(0, 0, 0, 0);    // restart from address 0
    gap6_frame();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
